// File: rtl/text_memory_loader.sv
// Boot-time text memory loader.
// Frame layout: a 4-byte little-endian word count N, then N*4 payload bytes forming
// little-endian words, then one checksum byte. Payload words are written to the text
// memory from word address 0. The loader then checks that the payload bytes plus the
// checksum byte sum to zero mod 256. The core is held in reset until a load passes.
module text_memory_loader #(
   parameter int unsigned TEXT_BITS = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 start,
   output logic                 wr_enable,
   output logic [TEXT_BITS-3:0] wr_address,
   output logic [31:0]          wr_data,
   output logic                 core_hold,
   output logic                 done,
   output logic                 error
);

   localparam int unsigned AW       = TEXT_BITS - 2;
   localparam logic [31:0] CAPACITY = 32'(1) << AW;

   typedef enum logic [2:0] {
      StHeader,
      StPayload,
      StCheck,
      StDone,
      StError
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [TEXT_BITS-2:0] word_cnt_q, word_cnt_d;
   logic [31:0]          count_q, count_d;
   logic [31:0]          shift_q, shift_d;
   logic [7:0]           acc_q, acc_d;
   logic                 wr_enable_q, wr_enable_d;
   logic [AW-1:0]        wr_address_q, wr_address_d;
   logic [31:0]          wr_data_q, wr_data_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic                 hold_q, hold_d;

   logic                 accept;
   logic [31:0]          next_word;
   logic [7:0]           check_sum;

   // Byte handshake depends only on state, never on in_valid.
   assign in_ready  = (state_q == StHeader) || (state_q == StPayload) || (state_q == StCheck);
   assign accept    = in_valid && in_ready;
   // Little-endian assembly: each new byte enters at the top and moves down.
   assign next_word = {in_data, shift_q[31:8]};
   assign check_sum = acc_q + in_data;

   // Next-state and datapath decode.
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      word_cnt_d   = word_cnt_q;
      count_d      = count_q;
      shift_d      = shift_q;
      acc_d        = acc_q;
      wr_enable_d  = 1'b0;
      wr_address_d = wr_address_q;
      wr_data_d    = wr_data_q;
      done_d       = done_q;
      error_d      = error_q;
      hold_d       = hold_q;

      unique case (state_q)
         StHeader: begin
            if (accept) begin
               shift_d    = next_word;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  count_d = next_word;
                  if (next_word > CAPACITY) begin
                     state_d = StError;
                     error_d = 1'b1;
                  end else if (next_word == 32'd0) begin
                     state_d = StCheck;
                  end else begin
                     state_d = StPayload;
                  end
               end
            end
         end
         StPayload: begin
            if (accept) begin
               shift_d    = next_word;
               acc_d      = acc_q + in_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  wr_enable_d  = 1'b1;
                  wr_address_d = word_cnt_q[AW-1:0];
                  wr_data_d    = next_word;
                  word_cnt_d   = word_cnt_q + 1'b1;
                  if (32'(word_cnt_d) == count_q) begin
                     state_d = StCheck;
                  end
               end
            end
         end
         StCheck: begin
            if (accept) begin
               if (check_sum == 8'd0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = StError;
                  error_d = 1'b1;
               end
            end
         end
         StDone, StError: begin
            if (start) begin
               state_d    = StHeader;
               byte_cnt_d = '0;
               word_cnt_d = '0;
               count_d    = '0;
               shift_d    = '0;
               acc_d      = '0;
               done_d     = 1'b0;
               error_d    = 1'b0;
               hold_d     = 1'b1;
            end
         end
         default: begin
            state_d = StHeader;
         end
      endcase
   end

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StHeader;
         byte_cnt_q   <= '0;
         word_cnt_q   <= '0;
         count_q      <= '0;
         shift_q      <= '0;
         acc_q        <= '0;
         wr_enable_q  <= 1'b0;
         wr_address_q <= '0;
         wr_data_q    <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         hold_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         word_cnt_q   <= word_cnt_d;
         count_q      <= count_d;
         shift_q      <= shift_d;
         acc_q        <= acc_d;
         wr_enable_q  <= wr_enable_d;
         wr_address_q <= wr_address_d;
         wr_data_q    <= wr_data_d;
         done_q       <= done_d;
         error_q      <= error_d;
         hold_q       <= hold_d;
      end
   end

   assign wr_enable  = wr_enable_q;
   assign wr_address = wr_address_q;
   assign wr_data    = wr_data_q;
   assign done       = done_q;
   assign error      = error_q;
   assign core_hold  = hold_q;

endmodule
